// File: rtl/pwl_stim_pkg.sv
// pwl_stim_pkg: shared types and helpers for the PWL stimulus source.
//   state_t  : playback FSM states (IDLE, LOAD, RUN, DONE)
//   seg_t    : one segment table entry at the default widths
//   sat_add  : width-generic saturating signed add
package pwl_stim_pkg;

    localparam int DEF_WIDTH     = 25;
    localparam int DEF_LEN_WIDTH = 16;
    // Widest value word sat_add can handle.
    localparam int SAT_MAX_W     = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [DEF_WIDTH-1:0] v_start;
        logic signed [DEF_WIDTH-1:0] slope;
        logic [DEF_LEN_WIDTH-1:0]    len;
    } seg_t;

    // Adds two sign-extended w-bit values one bit wider than the operands
    // and clamps the sum to the signed w-bit range. Callers sign-extend
    // into SAT_MAX_W bits and keep the low w bits of the result.
    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W:0] sum;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        sum = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
        hi  = ((SAT_MAX_W+1)'(1) <<< (w - 1)) - (SAT_MAX_W+1)'(1);
        lo  = -((SAT_MAX_W+1)'(1) <<< (w - 1));
        if (sum > hi)
            sat_add = hi[SAT_MAX_W-1:0];
        else if (sum < lo)
            sat_add = lo[SAT_MAX_W-1:0];
        else
            sat_add = sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/pwl_stim_table.sv
// pwl_stim_table: N_SEG-deep segment storage for pwl_stim.
//   clk                          write clock (no reset: contents are don't-care until written)
//   wr_en/wr_addr/wr_*           synchronous write port, one full segment per strobe
//   rd_addr                      read index (current segment)
//   rd_v_start/rd_slope/rd_len   asynchronous read data
module pwl_stim_table
    import pwl_stim_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int N_SEG     = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(N_SEG)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_v_start,
    input  logic [WIDTH-1:0]         wr_slope,
    input  logic [LEN_WIDTH-1:0]     wr_len,
    input  logic [$clog2(N_SEG)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_v_start,
    output logic [WIDTH-1:0]         rd_slope,
    output logic [LEN_WIDTH-1:0]     rd_len
);

    logic [WIDTH-1:0]     v_mem     [N_SEG];
    logic [WIDTH-1:0]     slope_mem [N_SEG];
    logic [LEN_WIDTH-1:0] len_mem   [N_SEG];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            v_mem[wr_addr]     <= wr_v_start;
            slope_mem[wr_addr] <= wr_slope;
            len_mem[wr_addr]   <= wr_len;
        end
    end

    // N_SEG is a power of 2, so every index value is in range.
    assign rd_v_start = v_mem[rd_addr];
    assign rd_slope   = slope_mem[rd_addr];
    assign rd_len     = len_mem[rd_addr];

endmodule

// File: rtl/pwl_stim.sv
// pwl_stim: piecewise-linear stimulus source feeding the analog model input.
// Each segment emits its start value for one cycle, then len values stepped
// by slope (saturating), one per enabled clk. Playback runs segments
// 0..last_seg, with last_seg captured at start.
//   clk, rst        clock, asynchronous active-low reset
//   en              step enable for RUN (LOAD proceeds regardless)
//   start, abort    control pulses; abort wins and returns to IDLE
//   last_seg        final segment index, sampled at start
//   wr_*            segment table write port (accepted only when not busy)
//   v_out           signed fixed-point stimulus, scale 2^EXPONENT
//   busy, done      in LOAD/RUN, in DONE
//   seg_idx         current segment index
//   wr_err          one-cycle pulse when a write arrives while busy
// Optional feature macro PWL_STIM_LOOP_EN: adds input loop; when high at the
// end of the final segment, playback restarts at segment 0 instead of DONE.
module pwl_stim
    import pwl_stim_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXPONENT  = -16,
    parameter int N_SEG     = 8,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic                     abort,
`ifdef PWL_STIM_LOOP_EN
    input  logic                     loop,
`endif
    input  logic [$clog2(N_SEG)-1:0] last_seg,
    input  logic                     wr_en,
    input  logic [$clog2(N_SEG)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_v_start,
    input  logic [WIDTH-1:0]         wr_slope,
    input  logic [LEN_WIDTH-1:0]     wr_len,
    output logic [WIDTH-1:0]         v_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_SEG)-1:0] seg_idx,
    output logic                     wr_err
);

    localparam int IW = $clog2(N_SEG);

    if (N_SEG < 2 || (N_SEG & (N_SEG - 1)) != 0) begin : g_bad_nseg
        $error("pwl_stim: N_SEG=%0d must be a power of 2 >= 2 (EXPONENT=%0d)", N_SEG, EXPONENT);
    end

    state_t                   state_q, state_d;
    logic [IW-1:0]            seg_q, seg_d;
    logic [IW-1:0]            last_q, last_d;
    logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
    logic signed [WIDTH-1:0]  v_q, v_d;
    logic                     wr_err_q, wr_err_d;

    logic                     tbl_we;
    logic                     busy_c;
    logic                     at_last;
    state_t                   fin_state;
    logic [IW-1:0]            fin_seg;
    logic signed [WIDTH-1:0]  rd_v_start;
    logic signed [WIDTH-1:0]  rd_slope;
    logic [LEN_WIDTH-1:0]     rd_len;

    pwl_stim_table #(
        .WIDTH     (WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .N_SEG     (N_SEG)
    ) u_table (
        .clk        (clk),
        .wr_en      (tbl_we),
        .wr_addr    (wr_addr),
        .wr_v_start (wr_v_start),
        .wr_slope   (wr_slope),
        .wr_len     (wr_len),
        .rd_addr    (seg_q),
        .rd_v_start (rd_v_start),
        .rd_slope   (rd_slope),
        .rd_len     (rd_len)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            seg_q    <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
            v_q      <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            v_q      <= v_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        v_d      = v_q;
        busy_c   = (state_q == LOAD) || (state_q == RUN);
        at_last  = (seg_q == last_q);
        // The table is only rewritten while no playback can be reading it.
        tbl_we   = wr_en && !busy_c;
        wr_err_d = wr_en && busy_c;

        // Where playback goes after the final segment's last output.
        fin_state = DONE;
        fin_seg   = seg_q;
`ifdef PWL_STIM_LOOP_EN
        if (loop) begin
            fin_state = LOAD;
            fin_seg   = '0;
        end
`endif

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = LOAD;
                        seg_d   = '0;
                        last_d  = last_seg;
                    end
                end
                LOAD: begin
                    v_d   = rd_v_start;
                    cnt_d = rd_len;
                    if (rd_len != '0) begin
                        state_d = RUN;
                    end else if (at_last) begin
                        state_d = fin_state;
                        seg_d   = fin_seg;
                    end else begin
                        seg_d = seg_q + 1'b1;
                    end
                end
                RUN: begin
                    if (en) begin
                        v_d   = WIDTH'(sat_add(SAT_MAX_W'(v_q), SAT_MAX_W'(rd_slope), WIDTH));
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == LEN_WIDTH'(1)) begin
                            if (at_last) begin
                                state_d = fin_state;
                                seg_d   = fin_seg;
                            end else begin
                                state_d = LOAD;
                                seg_d   = seg_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign v_out   = v_q;
    assign busy    = busy_c;
    assign done    = (state_q == DONE);
    assign seg_idx = seg_q;
    assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_pwl_stim.sv
module tb_pwl_stim;
    import pwl_stim_pkg::*;

    localparam int     WIDTH     = 25;
    localparam int     N_SEG     = 8;
    localparam int     LEN_WIDTH = 16;
    localparam int     IW        = $clog2(N_SEG);
    localparam longint VMAX      = (longint'(1) <<< (WIDTH - 1)) - 1;
    localparam longint VMIN      = -(longint'(1) <<< (WIDTH - 1));

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en, start, abort, wr_en;
    logic [IW-1:0]        last_seg, wr_addr, seg_idx;
    logic [WIDTH-1:0]     wr_v_start, wr_slope, v_out;
    logic [LEN_WIDTH-1:0] wr_len;
    logic                 busy, done, wr_err;
`ifdef PWL_STIM_LOOP_EN
    logic                 loop = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // Shadow of what the table should hold, and the expected output stream.
    seg_t shadow [N_SEG];
    typedef struct { longint v; bit needs_en; int seg; } ent_t;
    ent_t   q[$];
    longint cur_v;

    always #5 clk = ~clk;

    pwl_stim #(.WIDTH(WIDTH), .EXPONENT(-16), .N_SEG(N_SEG), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
`ifdef PWL_STIM_LOOP_EN
        .loop(loop),
`endif
        .last_seg(last_seg), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_v_start(wr_v_start), .wr_slope(wr_slope), .wr_len(wr_len),
        .v_out(v_out), .busy(busy), .done(done), .seg_idx(seg_idx), .wr_err(wr_err)
    );

    function automatic logic [WIDTH-1:0] w(input longint x);
        return x[WIDTH-1:0];
    endfunction

    function automatic longint sv(input logic [WIDTH-1:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint clamp(input longint x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input longint v, input longint s, input int l);
        wr_en = 1'b1; wr_addr = IW'(a); wr_v_start = w(v); wr_slope = w(s); wr_len = LEN_WIDTH'(l);
        tick();
        wr_en = 1'b0;
        shadow[a].v_start = w(v);
        shadow[a].slope   = w(s);
        shadow[a].len     = LEN_WIDTH'(l);
    endtask

    // Expected output stream: each segment gives its start value (emitted
    // regardless of en), then len clamped steps (each needing en).
    task automatic build_model(input int last);
        longint v;
        q.delete();
        for (int s = 0; s <= last; s++) begin
            v = longint'(shadow[s].v_start);
            q.push_back(ent_t'{v, 1'b0, s});
            for (int k = 0; k < int'(shadow[s].len); k++) begin
                v = clamp(v + longint'(shadow[s].slope));
                q.push_back(ent_t'{v, 1'b1, s});
            end
        end
    endtask

    task automatic do_start(input int last);
        last_seg = IW'(last); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        total++;
        if (v_out !== '0 || busy !== 1'b0 || done !== 1'b0 || seg_idx !== '0 || wr_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_async v=%0d busy=%b done=%b seg=%0d wr_err=%b exp all 0", sv(v_out), busy, done, seg_idx, wr_err);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (v_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release v=%0d busy=%b done=%b exp 0/0/0", sv(v_out), busy, done);
        end
    endtask

    task automatic test_ramp();
        longint exp_v [4] = '{0, 4, 8, 12};
        wr(0, 0, 4, 3);
        en = 1'b1;
        do_start(0);
        total++;
        if (busy !== 1'b1 || v_out !== '0) begin
            bad++;
            $display("FAIL ramp_load busy=%b v=%0d exp busy=1 v=0", busy, sv(v_out));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (v_out !== w(exp_v[i]) || done !== (i == 3)) begin
                bad++;
                $display("FAIL ramp[%0d] v=%0d done=%b exp v=%0d done=%b", i, sv(v_out), done, exp_v[i], i == 3);
            end
        end
        tick();
        total++;
        if (v_out !== w(12) || done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ramp_hold v=%0d done=%b busy=%b exp 12/1/0", sv(v_out), done, busy);
        end
    endtask

    task automatic test_two_seg();
        longint exp_v [5] = '{100, 90, 80, -50, -50};
        int     exp_s [5] = '{0, 0, 1, 1, 1};
        wr(0, 100, -10, 2);
        wr(1, -50, 0, 1);
        do_start(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (v_out !== w(exp_v[i]) || seg_idx !== IW'(exp_s[i]) || done !== (i == 4)) begin
                bad++;
                $display("FAIL two_seg[%0d] v=%0d seg=%0d done=%b exp v=%0d seg=%0d done=%b",
                         i, sv(v_out), seg_idx, done, exp_v[i], exp_s[i], i == 4);
            end
        end
    endtask

    task automatic test_stall();
        bit     en_seq [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1};
        longint exp_v  [10] = '{10, 10, 10, 13, 13, 13, 13, 16, 19, 22};
        wr(0, 10, 3, 4);
        do_start(0);
        for (int i = 0; i < 10; i++) begin
            en = en_seq[i];
            tick();
            total++;
            if (v_out !== w(exp_v[i]) || busy !== (i != 9) || done !== (i == 9)) begin
                bad++;
                $display("FAIL stall[%0d] v=%0d busy=%b done=%b exp v=%0d busy=%b done=%b",
                         i, sv(v_out), busy, done, exp_v[i], i != 9, i == 9);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_saturation();
        longint exp_v [8] = '{VMAX - 2, VMAX, VMAX, VMAX, VMAX, VMIN + 1, VMIN, VMIN};
        wr(0, VMAX - 2, 2, 4);
        wr(1, VMIN + 1, -5, 2);
        do_start(1);
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (v_out !== w(exp_v[i]) || done !== (i == 7)) begin
                bad++;
                $display("FAIL sat[%0d] v=%0d done=%b exp v=%0d done=%b", i, sv(v_out), done, exp_v[i], i == 7);
            end
        end
    endtask

    task automatic test_abort();
        wr(0, 0, 1, 10);
        do_start(0);
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || v_out !== w(2)) begin
            bad++;
            $display("FAIL abort_run busy=%b done=%b v=%0d exp 0/0/2", busy, done, sv(v_out));
        end
        tick();
        total++;
        if (busy !== 1'b0 || v_out !== w(2)) begin
            bad++;
            $display("FAIL abort_idle busy=%b v=%0d exp 0/2", busy, sv(v_out));
        end
        // start while busy must not restart the run
        do_start(0);
        tick(); tick();
        do_start(0);
        total++;
        if (v_out !== w(2) || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy v=%0d busy=%b exp 2/1", sv(v_out), busy);
        end
        tick();
        total++;
        if (v_out !== w(3)) begin
            bad++;
            $display("FAIL start_busy_next v=%0d exp 3", sv(v_out));
        end
        abort = 1'b1; tick(); abort = 1'b0;
        // abort out of DONE clears done and holds v_out
        wr(0, 5, 1, 1);
        do_start(0);
        tick(); tick();
        total++;
        if (done !== 1'b1 || v_out !== w(6)) begin
            bad++;
            $display("FAIL abort_pre done=%b v=%0d exp 1/6", done, sv(v_out));
        end
        abort = 1'b1; tick(); abort = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || v_out !== w(6)) begin
            bad++;
            $display("FAIL abort_done done=%b busy=%b v=%0d exp 0/0/6", done, busy, sv(v_out));
        end
        // start and abort together: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || v_out !== w(6)) begin
            bad++;
            $display("FAIL start_abort busy=%b done=%b v=%0d exp 0/0/6", busy, done, sv(v_out));
        end
    endtask

    task automatic test_write_busy();
        wr(0, 0, 1, 10);
        do_start(0);
        tick();
        wr_en = 1'b1; wr_addr = '0; wr_v_start = w(999); wr_slope = w(7); wr_len = LEN_WIDTH'(2);
        tick();
        wr_en = 1'b0;
        total++;
        if (wr_err !== 1'b1) begin
            bad++;
            $display("FAIL wr_err_pulse got=%b exp=1", wr_err);
        end
        tick();
        total++;
        if (wr_err !== 1'b0) begin
            bad++;
            $display("FAIL wr_err_clear got=%b exp=0", wr_err);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        wr(1, 3, 3, 3);
        total++;
        if (wr_err !== 1'b0) begin
            bad++;
            $display("FAIL wr_idle_err got=%b exp=0", wr_err);
        end
        do_start(0);
        tick();
        total++;
        if (v_out !== w(0)) begin
            bad++;
            $display("FAIL wr_dropped_vstart v=%0d exp 0", sv(v_out));
        end
        tick();
        total++;
        if (v_out !== w(1)) begin
            bad++;
            $display("FAIL wr_dropped_slope v=%0d exp 1", sv(v_out));
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

`ifdef PWL_STIM_LOOP_EN
    task automatic test_loop();
        wr(0, 0, 1, 1);
        loop = 1'b1;
        do_start(0);
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (v_out !== w(i % 2) || done !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL loop[%0d] v=%0d done=%b busy=%b exp v=%0d 0/1", i, sv(v_out), done, busy, i % 2);
            end
        end
        abort = 1'b1; tick(); abort = 1'b0;
        loop = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL loop_abort busy=%b done=%b exp 0/0", busy, done);
        end
    endtask
`endif

    task automatic test_random();
        ent_t e;
        int   last, guard, exp_seg;
        longint v, s;
        rst = 1'b0; tick(); rst = 1'b1;
        cur_v = 0;
        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < N_SEG; a++) begin
                v = longint'($signed(WIDTH'($urandom)));
                if ($urandom_range(0, 3) == 0)
                    s = longint'($signed(WIDTH'($urandom)));
                else
                    s = longint'(int'($urandom_range(0, 200)) - 100);
                wr(a, v, s, int'($urandom_range(0, 4)));
            end
            last = int'($urandom_range(0, N_SEG - 1));
            build_model(last);
            en = 1'b1;
            do_start(last);
            total++;
            if (busy !== 1'b1 || v_out !== w(cur_v) || seg_idx !== '0) begin
                bad++;
                $display("FAIL rnd_start it=%0d busy=%b v=%0d seg=%0d exp 1/%0d/0", it, busy, sv(v_out), seg_idx, cur_v);
            end
            guard = 0;
            while (q.size() != 0 && guard < 400) begin
                en = ($urandom_range(0, 3) != 0);
                last_seg = IW'($urandom_range(0, N_SEG - 1));
                tick();
                guard++;
                if (!q[0].needs_en || en) begin
                    e = q.pop_front();
                    cur_v = e.v;
                end
                exp_seg = (q.size() != 0) ? q[0].seg : last;
                total++;
                if (v_out !== w(cur_v) || busy !== (q.size() != 0) || done !== (q.size() == 0) ||
                    seg_idx !== IW'(exp_seg)) begin
                    bad++;
                    $display("FAIL rnd it=%0d cyc=%0d v=%0d busy=%b done=%b seg=%0d exp v=%0d busy=%b done=%b seg=%0d",
                             it, guard, sv(v_out), busy, done, seg_idx, cur_v, q.size() != 0, q.size() == 0, exp_seg);
                end
            end
            total++;
            if (guard >= 400) begin
                bad++;
                $display("FAIL rnd_budget it=%0d cycles=%0d limit=400", it, guard);
            end
        end
    endtask

    initial begin
        en = 1'b0; start = 1'b0; abort = 1'b0; wr_en = 1'b0; last_seg = '0;
        wr_addr = '0; wr_v_start = '0; wr_slope = '0; wr_len = '0;
        test_reset();
        test_ramp();
        test_two_seg();
        test_stall();
        test_saturation();
        test_abort();
        test_write_busy();
`ifdef PWL_STIM_LOOP_EN
        test_loop();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
